// File: rtl/pwm_pkg.sv
// Shared definitions for the dead-time PWM driver: FSM state encoding and
// default dead-time parameters.
package pwm_pkg;

  typedef enum logic [2:0] {
    SAFE     = 3'd0,
    LO_ON    = 3'd1,
    DT_TO_HI = 3'd2,
    HI_ON    = 3'd3,
    DT_TO_LO = 3'd4
  } pwm_state_e;

  localparam int PWM_DT_WIDTH = 4;
  localparam int PWM_DT_RESET = 2;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side driver with programmable dead time between edges.
// Optional aborted-dead-time counter enabled by macro PWM_DT_ABORT_CNT_EN.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH,
  parameter int DT_RESET = PWM_DT_RESET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dt_in,
  input  logic                dt_wr,
  output logic                hi_out,
  output logic                lo_out,
  output logic [DT_WIDTH-1:0] dt_reg,
  output logic [7:0]          abort_cnt
);

  localparam logic [DT_WIDTH-1:0] CNT_ZERO = {DT_WIDTH{1'b0}};
  localparam logic [DT_WIDTH-1:0] CNT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DT_WIDTH-1:0] DT_INIT  = DT_WIDTH'(DT_RESET);

  pwm_state_e          state_r;
  pwm_state_e          state_nxt_s;
  logic [DT_WIDTH-1:0] cnt_r;
  logic [DT_WIDTH-1:0] cnt_nxt_s;
  logic                pwm_q;
  logic                dt_zero_s;

  // A zero dead time skips the dead-time states entirely.
  assign dt_zero_s = (dt_reg == CNT_ZERO);

  // Next-state and counter logic; a reversal inside dead time re-targets the opposite side.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (!ena) begin
      state_nxt_s = SAFE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        SAFE, LO_ON, HI_ON: begin
          if (pwm_q && (state_r != HI_ON)) begin
            state_nxt_s = dt_zero_s ? HI_ON : DT_TO_HI;
            cnt_nxt_s   = dt_reg;
          end else if (!pwm_q && (state_r != LO_ON)) begin
            state_nxt_s = dt_zero_s ? LO_ON : DT_TO_LO;
            cnt_nxt_s   = dt_reg;
          end else begin
            state_nxt_s = state_r;
          end
        end
        DT_TO_HI: begin
          if (!pwm_q) begin
            state_nxt_s = dt_zero_s ? LO_ON : DT_TO_LO;
            cnt_nxt_s   = dt_reg;
          end else if (cnt_r <= CNT_ONE) begin
            state_nxt_s = HI_ON;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        DT_TO_LO: begin
          if (pwm_q) begin
            state_nxt_s = dt_zero_s ? HI_ON : DT_TO_HI;
            cnt_nxt_s   = dt_reg;
          end else if (cnt_r <= CNT_ONE) begin
            state_nxt_s = LO_ON;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = SAFE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, sample stage, counter and dead-time register; counter load sees the old dt_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SAFE;
      pwm_q   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      dt_reg  <= DT_INIT;
    end else begin
      state_r <= state_nxt_s;
      pwm_q   <= pwm_in;
      cnt_r   <= cnt_nxt_s;
      if (dt_wr) begin
        dt_reg <= dt_in;
      end
    end
  end

  assign hi_out = (state_r == HI_ON);
  assign lo_out = (state_r == LO_ON);

`ifdef PWM_DT_ABORT_CNT_EN
  logic       abort_s;
  logic [7:0] abort_cnt_r;

  // Abort event: sampled PWM reverses while a dead time is still counting.
  always_comb begin
    abort_s = 1'b0;
    if (ena && (((state_r == DT_TO_HI) && !pwm_q) || ((state_r == DT_TO_LO) && pwm_q))) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Saturating abort counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_cnt_r <= 8'h00;
    end else if (abort_s && (abort_cnt_r != 8'hFF)) begin
      abort_cnt_r <= abort_cnt_r + 8'h01;
    end
  end

  assign abort_cnt = abort_cnt_r;
`else
  assign abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed self-checking bench for pwm_deadtime: reset, dead-time timing,
// zero dead time, abort, mid-count writes, enable drop and reset mid dead time.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       pwm_in;
  logic [3:0] dt_in;
  logic       dt_wr;
  logic       hi_out;
  logic       lo_out;
  logic [3:0] dt_reg;
  logic [7:0] abort_cnt;

  int checks = 0;
  int errors = 0;

`ifdef PWM_DT_ABORT_CNT_EN
  localparam logic [7:0] EXP_ABORT = 8'd1;
`else
  localparam logic [7:0] EXP_ABORT = 8'd0;
`endif

  pwm_deadtime dut (
    .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in), .dt_in(dt_in), .dt_wr(dt_wr),
    .hi_out(hi_out), .lo_out(lo_out), .dt_reg(dt_reg), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {hi_out, lo_out} check
  task automatic chk_out(input string name, input logic [1:0] exp);
    checks++;
    if ({hi_out, lo_out} !== exp) begin
      errors++;
      $display("FAIL %s: hi_lo=%b expected %b at %0t", name, {hi_out, lo_out}, exp, $time);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; pwm_in = 1'b0; dt_in = 4'd0; dt_wr = 1'b0;
    step(); step();
    chk_out("reset_outs", 2'b00);
    checks++;
    if (dt_reg !== 4'd2) begin errors++; $display("FAIL reset_dt_reg: got %0d expected 2", dt_reg); end
    checks++;
    if (abort_cnt !== 8'd0) begin errors++; $display("FAIL reset_abort: got %0d expected 0", abort_cnt); end
  endtask

  task automatic test_startup();
    ena = 1'b1; pwm_in = 1'b0;
    step();
    rst = 1'b0;
    step(); chk_out("start_e1", 2'b00);
    step(); chk_out("start_e2", 2'b00);
    step(); chk_out("start_e3", 2'b01);
  endtask

  task automatic test_deadtime3();
    dt_wr = 1'b1; dt_in = 4'd3;
    step();
    dt_wr = 1'b0;
    checks++;
    if (dt_reg !== 4'd3) begin errors++; $display("FAIL dt3_write: got %0d expected 3", dt_reg); end
    chk_out("dt3_lo_hold", 2'b01);
    pwm_in = 1'b1;
    step(); chk_out("dt3_k", 2'b01);
    step(); chk_out("dt3_k1", 2'b00);
    step(); chk_out("dt3_k2", 2'b00);
    step(); chk_out("dt3_k3", 2'b00);
    step(); chk_out("dt3_k4", 2'b10);
  endtask

  task automatic test_zero_dt();
    dt_wr = 1'b1; dt_in = 4'd0;
    step();
    dt_wr = 1'b0;
    pwm_in = 1'b0;
    step(); chk_out("dt0_fall_k", 2'b10);
    step(); chk_out("dt0_fall_k1", 2'b01);
    pwm_in = 1'b1;
    step(); chk_out("dt0_rise_k", 2'b01);
    step(); chk_out("dt0_rise_k1", 2'b10);
  endtask

  task automatic test_abort();
    dt_wr = 1'b1; dt_in = 4'd4;
    step();
    dt_wr = 1'b0;
    pwm_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_out("abort_setup_lo", 2'b01);
    checks++;
    if (abort_cnt !== 8'd0) begin errors++; $display("FAIL abort_pre: got %0d expected 0", abort_cnt); end
    pwm_in = 1'b1;
    step();
    pwm_in = 1'b0;
    step(); chk_out("abort_dt_to_hi", 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("abort_dead", 2'b00);
    end
    step(); chk_out("abort_back_lo", 2'b01);
    checks++;
    if (abort_cnt !== EXP_ABORT) begin
      errors++; $display("FAIL abort_cnt: got %0d expected %0d", abort_cnt, EXP_ABORT);
    end
  endtask

  task automatic test_write_midcount();
    pwm_in = 1'b1;
    step();
    dt_wr = 1'b1; dt_in = 4'd1;
    step();
    dt_wr = 1'b0;
    chk_out("wr_load_old", 2'b00);
    step(); step();
    step(); chk_out("wr_k4", 2'b00);
    step(); chk_out("wr_k5", 2'b10);
    checks++;
    if (dt_reg !== 4'd1) begin errors++; $display("FAIL wr_dt_reg: got %0d expected 1", dt_reg); end
  endtask

  task automatic test_ena();
    dt_wr = 1'b1; dt_in = 4'd2;
    step();
    dt_wr = 1'b0;
    ena = 1'b0;
    step(); chk_out("ena_drop", 2'b00);
    step(); chk_out("ena_hold", 2'b00);
    checks++;
    if (dt_reg !== 4'd2) begin errors++; $display("FAIL ena_dt_kept: got %0d expected 2", dt_reg); end
    ena = 1'b1;
    step(); chk_out("ena_m", 2'b00);
    step(); chk_out("ena_m1", 2'b00);
    step(); chk_out("ena_m2", 2'b10);
  endtask

  task automatic test_reset_mid();
    pwm_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_out("rmid_lo", 2'b01);
    pwm_in = 1'b1;
    step(); step();
    chk_out("rmid_in_dt", 2'b00);
    rst = 1'b1; dt_wr = 1'b1; dt_in = 4'd7;
    step();
    rst = 1'b0; dt_wr = 1'b0;
    chk_out("rmid_outs", 2'b00);
    checks++;
    if (dt_reg !== 4'd2) begin errors++; $display("FAIL rmid_dt_reg: got %0d expected 2", dt_reg); end
    checks++;
    if (abort_cnt !== 8'd0) begin errors++; $display("FAIL rmid_abort: got %0d expected 0", abort_cnt); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_deadtime3();
    test_zero_dt();
    test_abort();
    test_write_midcount();
    test_ena();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 4: width of dead-time register and counter.
REQ-002 SHALL have parameter DT_RESET, default 2: dead-time value loaded at reset.
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ena, input, 1: enable; low forces safe state.
REQ-006 SHALL have port pwm_in, input, 1: raw PWM from pwm_generator, synchronous to clk.
REQ-007 SHALL have port dt_in, input, DT_WIDTH: new dead-time value, from decoded SPI data bits [DT_WIDTH-1:0].
REQ-008 SHALL have port dt_wr, input, 1: one-cycle write strobe for dt_in, address 4'h9.
REQ-009 SHALL have port hi_out, output, 1: high-side drive.
REQ-010 SHALL have port lo_out, output, 1: low-side drive.
REQ-011 SHALL have port dt_reg, output, DT_WIDTH: current dead-time register.
REQ-012 SHALL have port abort_cnt, output, 8: aborted dead-time count (see Configuration).

Function
REQ-013 SHALL register pwm_in into pwm_q every cycle (1-cycle sample stage).
REQ-014 SHALL implement states SAFE, LO_ON, DT_TO_HI, HI_ON, DT_TO_LO; hi_out = (state==HI_ON), lo_out = (state==LO_ON), both decoded from registered state.
REQ-015 SAFE with ena=1: pwm_q=1 -> DT_TO_HI, pwm_q=0 -> DT_TO_LO, counter loaded with dt_reg.
REQ-016 LO_ON with pwm_q=1 -> DT_TO_HI; HI_ON with pwm_q=0 -> DT_TO_LO; counter loaded with dt_reg.
REQ-017 Any transition into DT_TO_HI/DT_TO_LO with dt_reg=0 SHALL go directly to HI_ON/LO_ON instead.
REQ-018 In DT_TO_x, counter SHALL decrement each cycle; at the edge where counter==1, state SHALL become HI_ON/LO_ON.
REQ-019 Both outputs SHALL be low for exactly dt_reg cycles between any two opposing output assertions; never simultaneously high.
REQ-020 Latency: pwm_in rise before edge k -> hi_out high after edge k+1+dt_reg.
REQ-021 pwm_q reversing during DT_TO_HI SHALL go to DT_TO_LO (and vice versa) with counter reloaded from dt_reg; counts as one abort.
REQ-022 dt_wr=1 SHALL load dt_in into dt_reg at that edge; an in-progress count SHALL be unaffected; new value applies at next load.
REQ-023 dt_wr and a counter load in the same cycle SHALL load the old dt_reg into the counter.
REQ-024 ena=0 SHALL force state SAFE next edge (both outputs low); dt_reg retained.

Reset
REQ-025 rst=1 SHALL set state SAFE, hi_out=0, lo_out=0, pwm_q=0, counter=0, dt_reg=DT_RESET, abort_cnt=0.
REQ-026 Reset SHALL take precedence over ena, dt_wr and pwm_in, including mid dead-time.

Configuration
REQ-027 Macro PWM_DT_ABORT_CNT_EN: defined -> abort_cnt increments per REQ-021 event, saturating at 8'hFF, cleared only by reset.
REQ-028 Without PWM_DT_ABORT_CNT_EN: abort_cnt tied to 0, no counter logic; all other behaviour identical.

Structure
REQ-029 State encoding type and DT_WIDTH/DT_RESET defaults SHALL live in shared package pwm_pkg.
REQ-030 No sub-module; counter and FSM SHALL be inline in pwm_deadtime.

Verification
REQ-031 Reset, ena=1, pwm_in=0, dt_reg=2 -> lo_out high after 3rd edge post-reset; hi_out stays 0.
REQ-032 LO_ON, dt_reg=3, pwm_in rises before edge k -> lo_out low after k+1, hi_out high after k+4.
REQ-033 dt_wr with dt_in=0 then pwm_in toggle -> outputs swap with no both-low cycle, 2-cycle latency.
REQ-034 dt_reg=4, pwm_in 1-cycle pulse high from LO_ON -> hi_out never high; abort_cnt=1 (macro on), 0 (off).
REQ-035 HI_ON, ena dropped -> both outputs 0 next edge; ena restored with dt_reg=2 -> re-entry through 2-cycle dead time.
REQ-036 rst asserted mid DT_TO_HI with dt_wr=1, dt_in=7 -> state SAFE, dt_reg=2, both outputs 0.
